// File: rtl/us_ctrl_pkg.sv
// Shared types and constants for the upsampler transmit sequencer.
// Symbol slots are SYM_CYC cycles long and aligned to the upsampler phase counter.
package us_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_PAY   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  localparam int SYM_CYC = 4;

  localparam logic [1:0] PRE_SYM_A = 2'b10;
  localparam logic [1:0] PRE_SYM_B = 2'b00;

  // Preamble alternates A,B,A,B... starting with slot 0.
  function automatic logic [1:0] pre_sym(input logic slot_lsb);
    return slot_lsb ? PRE_SYM_B : PRE_SYM_A;
  endfunction

endpackage

// File: rtl/us_ctrl_slot_cnt.sv
// Slot timing for us_tx_ctrl: 2-bit symbol phase plus a down-counter that
// counts remaining slots (PRE/PAY) or remaining cycles (FLUSH/GAP).
module us_ctrl_slot_cnt
  import us_ctrl_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             phase_clr,
  input  logic             phase_en,
  input  logic             cnt_load,
  input  logic [LEN_W-1:0] cnt_val,
  input  logic             cnt_step,
  output logic [1:0]       phase,
  output logic [LEN_W-1:0] cnt,
  output logic             last_phase,
  output logic             last_slot
);

  logic [1:0]       phase_r;
  logic [LEN_W-1:0] cnt_r;

  // Symbol phase: free-runs while the upsampler is enabled, wraps 3->0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_r <= 2'd0;
    end else if (phase_clr) begin
      phase_r <= 2'd0;
    end else if (phase_en) begin
      phase_r <= phase_r + 2'd1;
    end else begin
      phase_r <= phase_r;
    end
  end

  // Remaining-unit counter; a load takes priority, and it never wraps below zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {LEN_W{1'b0}};
    end else if (cnt_load) begin
      cnt_r <= cnt_val;
    end else if (cnt_step && (cnt_r != {LEN_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign phase      = phase_r;
  assign cnt        = cnt_r;
  assign last_phase = (phase_r == 2'(SYM_CYC - 1));
  assign last_slot  = (cnt_r == {{(LEN_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/us_tx_ctrl.sv
// Transmit sequencer for the 4x upsampler: preamble, N payload symbols pulled
// over valid/ready, pipeline flush, then an enable-low guard gap.
module us_tx_ctrl
  import us_ctrl_pkg::*;
#(
  parameter int LEN_W     = 8,
  parameter int PRE_LEN   = 4,
  parameter int FLUSH_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             sym_valid,
  input  logic [1:0]       sym_data,
  output logic             sym_ready,
  output logic             us_en,
  output logic [1:0]       us_din,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  state_e           state_r, state_s;
  logic [LEN_W-1:0] len_r;

  logic             sym_ready_r, us_en_r, busy_r, done_r, underrun_r;
  logic [1:0]       us_din_r;
  logic             sym_ready_s, us_en_s, busy_s, done_s, underrun_s;
  logic [1:0]       us_din_s, load_sym_s;

  logic             phase_clr_s, phase_en_s, cnt_load_s, cnt_step_s;
  logic [LEN_W-1:0] cnt_val_s, pre_next_s;
  logic [1:0]       phase_s;
  logic [LEN_W-1:0] cnt_s;
  logic             last_phase_s, last_slot_s;

  us_ctrl_slot_cnt #(.LEN_W(LEN_W)) u_slot_cnt (
    .clk        (clk),
    .reset      (reset),
    .phase_clr  (phase_clr_s),
    .phase_en   (phase_en_s),
    .cnt_load   (cnt_load_s),
    .cnt_val    (cnt_val_s),
    .cnt_step   (cnt_step_s),
    .phase      (phase_s),
    .cnt        (cnt_s),
    .last_phase (last_phase_s),
    .last_slot  (last_slot_s)
  );

  // State register and latched frame length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      len_r   <= {LEN_W{1'b0}};
    end else begin
      state_r <= state_s;
      len_r   <= ((state_r == ST_IDLE) && start) ? frame_len : len_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  state_s = (start && (frame_len != {LEN_W{1'b0}})) ? ST_PRE : ST_IDLE;
      ST_PRE:   state_s = (last_phase_s && last_slot_s) ? ST_PAY : ST_PRE;
      ST_PAY:   state_s = (last_phase_s && last_slot_s) ? ST_FLUSH : ST_PAY;
      ST_FLUSH: state_s = last_slot_s ? ST_GAP : ST_FLUSH;
      ST_GAP:   state_s = last_slot_s ? ST_IDLE : ST_GAP;
      default:  state_s = ST_IDLE;
    endcase
  end

  assign load_sym_s = sym_valid ? sym_data : 2'b00;
  assign pre_next_s = LEN_W'(PRE_LEN) - cnt_s + {{(LEN_W-1){1'b0}}, 1'b1};

  // Counter control and next values of the registered outputs.
  always_comb begin
    phase_clr_s = 1'b0;
    phase_en_s  = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_val_s   = {LEN_W{1'b0}};
    cnt_step_s  = 1'b0;
    sym_ready_s = 1'b0;
    us_din_s    = us_din_r;
    case (state_r)
      ST_IDLE: begin
        if (state_s == ST_PRE) begin
          cnt_load_s = 1'b1;
          cnt_val_s  = LEN_W'(PRE_LEN);
          us_din_s   = PRE_SYM_A;
        end else begin
          us_din_s   = 2'b00;
        end
      end
      ST_PRE: begin
        phase_en_s  = 1'b1;
        sym_ready_s = (phase_s == 2'd2) && last_slot_s;
        if (last_phase_s && last_slot_s) begin
          cnt_load_s = 1'b1;
          cnt_val_s  = len_r;
          us_din_s   = load_sym_s;
        end else if (last_phase_s) begin
          cnt_step_s = 1'b1;
          us_din_s   = pre_sym(pre_next_s[0]);
        end else begin
          us_din_s   = us_din_r;
        end
      end
      ST_PAY: begin
        phase_en_s  = 1'b1;
        sym_ready_s = (phase_s == 2'd2) && !last_slot_s;
        if (last_phase_s && last_slot_s) begin
          cnt_load_s = 1'b1;
          cnt_val_s  = LEN_W'(FLUSH_CYC);
          us_din_s   = 2'b00;
        end else if (last_phase_s) begin
          cnt_step_s = 1'b1;
          us_din_s   = load_sym_s;
        end else begin
          us_din_s   = us_din_r;
        end
      end
      ST_FLUSH: begin
        phase_en_s = 1'b1;
        us_din_s   = 2'b00;
        if (last_slot_s) begin
          phase_clr_s = 1'b1;
          cnt_load_s  = 1'b1;
          cnt_val_s   = LEN_W'(GAP_CYC);
        end else begin
          cnt_step_s  = 1'b1;
        end
      end
      ST_GAP: begin
        us_din_s = 2'b00;
        if (last_slot_s) begin
          cnt_load_s = 1'b1;
          cnt_val_s  = {LEN_W{1'b0}};
        end else begin
          cnt_step_s = 1'b1;
        end
      end
      default: begin
        phase_clr_s = 1'b1;
        us_din_s    = 2'b00;
      end
    endcase
  end

  assign busy_s     = (state_s != ST_IDLE);
  assign us_en_s    = (state_s == ST_PRE) || (state_s == ST_PAY) || (state_s == ST_FLUSH);
  assign done_s     = (state_r == ST_GAP) && (state_s == ST_IDLE);
  // sym_ready_r high means this edge is a load edge.
  assign underrun_s = sym_ready_r && !sym_valid;

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_ready_r <= 1'b0;
      us_en_r     <= 1'b0;
      us_din_r    <= 2'b00;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      sym_ready_r <= sym_ready_s;
      us_en_r     <= us_en_s;
      us_din_r    <= us_din_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      underrun_r  <= underrun_s;
    end
  end

  assign sym_ready = sym_ready_r;
  assign us_en     = us_en_r;
  assign us_din    = us_din_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign underrun  = underrun_r;

endmodule

// File: tb/tb_us_tx_ctrl.sv
// Self-checking bench for us_tx_ctrl: a frame-level timeline model predicts
// every output per cycle from frame length, preamble rule and the source's behaviour.
module tb_us_tx_ctrl;

  localparam int LEN_W     = 8;
  localparam int PRE_LEN   = 4;
  localparam int FLUSH_CYC = 4;
  localparam int GAP_CYC   = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic             sym_valid = 1'b0;
  logic [1:0]       sym_data = 2'b00;
  logic             sym_ready, us_en, busy, done, underrun;
  logic [1:0]       us_din;

  int checks = 0;
  int failures = 0;
  int forced_data[$];

  us_tx_ctrl #(
    .LEN_W(LEN_W), .PRE_LEN(PRE_LEN), .FLUSH_CYC(FLUSH_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .frame_len (frame_len),
    .sym_valid (sym_valid),
    .sym_data  (sym_data),
    .sym_ready (sym_ready),
    .us_en     (us_en),
    .us_din    (us_din),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outs(input string tag, input int en, input int din, input int bsy,
                            input int dn, input int rdy, input int urun);
    check({tag, " us_en"},     8'(us_en),     8'(en));
    check({tag, " us_din"},    8'(us_din),    8'(din));
    check({tag, " busy"},      8'(busy),      8'(bsy));
    check({tag, " done"},      8'(done),      8'(dn));
    check({tag, " sym_ready"}, 8'(sym_ready), 8'(rdy));
    check({tag, " underrun"},  8'(underrun),  8'(urun));
  endtask

  task automatic idle_cycles(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      sym_valid = 1'($urandom_range(1));
      sym_data  = 2'($urandom_range(3));
      @(posedge clk); #1;
      check_outs("idle", 0, 0, 0, 0, 0, 0);
    end
  endtask

  // Runs one frame of n symbols. Leaves the bench in the done cycle (or in
  // idle after an abort) so a caller may start the next frame immediately.
  task automatic run_frame(input int n, input int vpct, input int drop_j,
                           input int restart_t, input int abort_t);
    int total, pre_end, pay_end, e_din, e_en, e_rdy, e_ur;
    int pay[$];
    bit miss[$];
    bit v;
    logic [1:0] d;
    string tg;
    pre_end = 4 * PRE_LEN;
    pay_end = 4 * (PRE_LEN + n);
    total   = pay_end + FLUSH_CYC + GAP_CYC;
    start     = 1'b1;
    frame_len = LEN_W'(n);
    @(posedge clk); #1;
    start     = 1'b0;
    frame_len = LEN_W'($urandom_range(255));
    for (int t = 0; t <= total; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      e_en  = (t < pay_end + FLUSH_CYC) ? 1 : 0;
      if (t < pre_end)      e_din = ((t / 4) % 2 == 0) ? 2 : 0;
      else if (t < pay_end) e_din = pay[(t - pre_end) / 4];
      else                  e_din = 0;
      e_rdy = (t >= pre_end - 1 && t < pay_end - 1 && t % 4 == 3) ? 1 : 0;
      e_ur  = (t >= pre_end && t < pay_end && t % 4 == 0 && miss[(t - pre_end) / 4]) ? 1 : 0;
      tg = $sformatf("n=%0d t=%0d", n, t);
      check_outs(tg, e_en, e_din, (t < total) ? 1 : 0, (t == total) ? 1 : 0, e_rdy, e_ur);
      if (t == abort_t) begin
        reset = 1'b0;
        #1;
        check_outs({tg, " abort"}, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check_outs({tg, " in reset"}, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        return;
      end
      start = (t == restart_t);
      if (t == restart_t) frame_len = LEN_W'($urandom_range(255, 1));
      if (t == total) return;
      v = ($urandom_range(99) < vpct);
      d = 2'($urandom_range(3));
      if (e_rdy == 1) begin
        if (pay.size() == drop_j) v = 1'b0;
        if (forced_data.size() > 0) d = 2'(forced_data.pop_front());
        pay.push_back(v ? int'(d) : 0);
        miss.push_back(!v);
      end
      sym_valid = v;
      sym_data  = d;
    end
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_outs("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    idle_cycles(2);

    // Directed N=2 frame with payload 11,01.
    forced_data = '{3, 1};
    run_frame(2, 100, -1, -1, -1);
    idle_cycles(3);

    // Source misses the second load edge.
    run_frame(3, 100, 1, -1, -1);
    idle_cycles(2);

    // Zero-length request is ignored.
    start = 1'b1;
    frame_len = '0;
    @(posedge clk); #1;
    check_outs("zero len", 0, 0, 0, 0, 0, 0);
    idle_cycles(3);

    // Start during PAY ignored; start in done cycle accepted back-to-back.
    run_frame(5, 100, -1, 4 * PRE_LEN + 5, -1);
    run_frame(4, 70, -1, -1, -1);
    idle_cycles(1);

    // Reset mid-PAY, then a clean full frame.
    run_frame(6, 100, -1, -1, 4 * PRE_LEN + 6);
    idle_cycles(2);
    run_frame(3, 80, -1, -1, -1);
    idle_cycles(1);

    // Randomized frames, some back-to-back.
    for (int i = 0; i < 8; i++) begin
      run_frame($urandom_range(12, 1), 60, -1, -1, -1);
      if ($urandom_range(1) == 1) idle_cycles($urandom_range(3, 1));
    end

    // Length boundaries: shortest and longest frames.
    run_frame(1, 50, -1, -1, -1);
    run_frame(255, 90, -1, -1, -1);
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/us_tx_ctrl.md
# us_tx_ctrl

Transmit sequencer for the 4x upsampler (US). It accepts a frame request and drives the upsampler's `en`/`din` pair for a fixed-length preamble followed by N payload symbols pulled from an upstream source over a valid/ready handshake. It then flushes the synchronizer pipeline and idles the upsampler for a guard gap. It sits between the baseband symbol source and US, and owns US symbol-slot alignment: a slot is 4 cycles, phase 0..3, matching US's internal counter.

## Interface
- `LEN_W`, 8: width of the payload length field.
- `PRE_LEN`, 4: number of preamble symbols.
- `FLUSH_CYC`, 4: cycles `us_en` stays high after the last payload slot to drain the SYN latency.
- `GAP_CYC`, 2: cycles `us_en` is held low before `done`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `start`  in  1  frame request, sampled in IDLE only.
- `frame_len`  in  LEN_W  payload symbol count N, sampled with `start`.
- `sym_valid`  in  1  source has a symbol.
- `sym_data`  in  2  payload symbol.
- `sym_ready`  out  1  controller accepts `sym_data` at this edge.
- `us_en`  out  1  to US `en`.
- `us_din`  out  2  to US `din`.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle end-of-frame pulse.
- `underrun`  out  1  one-cycle pulse: payload symbol missing at load edge.

## Operation
- States: IDLE, PRE, PAY, FLUSH, GAP.
- IDLE: `start`=1 and `frame_len`≠0 → PRE. `start` with `frame_len`=0 is ignored. `start` outside IDLE is ignored.
- PRE: PRE_LEN slots. Slot k drives `us_din`={~k[0],1'b0}, i.e. 10,00,10,00…
  - After the last slot → PAY.
- PAY: N slots. A payload counter counts down from N.
  - After the last slot → FLUSH.
- FLUSH: `us_en`=1, `us_din`=00 for FLUSH_CYC cycles → GAP.
- GAP: `us_en`=0, `us_din`=00 for GAP_CYC cycles → IDLE. This clears the US counter.
- Loading: `sym_ready`=1 only during phase 3 of the slot immediately preceding each payload slot. That is the last PRE slot and PAY slots 0..N-2.
  - At that edge, `sym_valid`=1 → `us_din`<=`sym_data`.
  - At that edge, `sym_valid`=0 → `us_din`<=00 and `underrun` pulses. The slot is still consumed; no stall.
- `us_din` is constant across all 4 cycles of a slot.
- Reset, including mid-frame: state=IDLE; phase and counters =0; all outputs 0. No `done` is issued for the aborted frame.

## Timing
- All outputs are registered.
- `start` sampled at edge E0 → from E0: state=PRE, phase=0, `us_en`=1, `us_din`=10, `busy`=1.
- Phase increments every cycle while `us_en`=1 and wraps 3→0. The slot advances on wrap.
- `busy` is high for exactly 4·(PRE_LEN+N)+FLUSH_CYC+GAP_CYC cycles.
- `done`=1 in the first IDLE cycle; `busy`=0 in that same cycle.
- A new `start` is accepted in the `done` cycle, giving back-to-back frames.
- Width rules:
  - Payload counter is LEN_W bits.
  - N=2^LEN_W−1 is legal.
  - No wrap occurs beyond N.

## Structure
- Package `us_ctrl_pkg`:
  - state enum;
  - `SYM_CYC`=4;
  - preamble symbol constants `PRE_SYM_A`=2'b10, `PRE_SYM_B`=2'b00.
- Sub-module `us_ctrl_slot_cnt`: 2-bit phase counter plus LEN_W slot down-counter, with `last_phase` and `last_slot` flags.
- The FSM and output registers live in the top module.

## Test plan
- Reset release, N=2, source always valid, data 11,01 → `us_din` sequence 10,00,10,00,11,01,00 (each held 4 cycles; final 00 is FLUSH) → `busy` 30 cycles → `done` pulse.
- N=3, `sym_valid` dropped at the second load edge → `underrun` pulses once; slot carries 00; frame length unchanged; `done` on time.
- `start` with `frame_len`=0 → stays IDLE; `busy`, `us_en` and `done` remain 0.
- `start` re-asserted during PAY and again in the `done` cycle → first is ignored; second starts a new PRE at the next edge.
- `reset` driven low mid-PAY → all outputs 0 immediately; no `done`. A following `start` runs a full frame correctly.
- Upsampler integration: instantiate US with its reset tied to the inverted `reset`; N=4 → US emits {Q,1} on each slot's phase-3 cycle; the preamble-then-payload bit order appears after the SYN delay.
